prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 20, meaning the total configuration bits in the downstream prog chain (must be at least 1).
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning the width of the input data word.
REQ-003 Port prog_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port prog_rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: begins a load when the block is idle.
REQ-006 Port abort, input, 1: cancels a load in progress.
REQ-007 Port data_in, input, WORD_W: configuration data word.
REQ-008 Port data_valid, input, 1: data_in holds a valid word.
REQ-009 Port data_ready, output, 1: the loader accepts data_in this cycle.
REQ-010 Port prog_in, output, 1: serial bit to the head of the chain.
REQ-011 Port prog_en, output, 1: chain shift enable.
REQ-012 Port busy, output, 1: a load is in progress.
REQ-013 Port done, output, 1: the last load completed; held until the next start.
REQ-014 Port err, output, 1: checksum mismatch, present only with the macro in REQ-030; held until the next start.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, SHIFT, CHECK and DONE; DONE behaves as IDLE but keeps done=1.
REQ-016 In IDLE or DONE, start=1 SHALL clear done and err, clear the bit counter, and enter FETCH on the next cycle.
REQ-017 In FETCH, data_ready SHALL be 1; a transfer occurs only when data_valid and data_ready are both 1. On transfer, the word is latched and the FSM enters SHIFT.
REQ-018 data_ready SHALL be 0 in every state except FETCH, and in CHECK as defined in REQ-031.
REQ-019 In SHIFT, prog_en and prog_in SHALL be registered outputs driving one bit per cycle, MSB of the word first.
- The first bit appears on the cycle after the transfer.
- The bit counter increments once per shifted bit.
REQ-020 SHIFT SHALL return to FETCH after WORD_W bits, or earlier when the bit counter reaches CHAIN_LEN.
- For a final partial word, only the upper (CHAIN_LEN mod WORD_W) bits are shifted; the remaining bits are discarded.
REQ-021 When the bit counter reaches CHAIN_LEN, the FSM SHALL go to DONE and set done=1 on the cycle after the last prog_en=1 cycle; CHECK is used instead when the macro is defined.
REQ-022 prog_en SHALL be 1 for exactly CHAIN_LEN cycles per load, and never outside SHIFT.
REQ-023 prog_in SHALL be 0 whenever prog_en=0.
REQ-024 busy SHALL equal 1 in FETCH, SHIFT and CHECK.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 abort SHALL take priority over all other inputs: on the next edge, state becomes IDLE, prog_en=0, and done stays 0. A partially loaded chain is left as is.
REQ-027 A data_valid gap during FETCH SHALL stall the load with prog_en=0 and no loss of bits.
REQ-028 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap during a load.

Reset
REQ-029 prog_rst=1 SHALL, on the next edge and from any state including mid-SHIFT, set:
- state to IDLE
- data_ready, prog_in, prog_en, busy, done and err all to 0
- the counters and word register cleared.

Configuration
REQ-030 The macro PROG_LOADER_CHECKSUM_EN SHALL enable the checksum feature.
- When defined: the loader keeps an XOR of every accepted data word, including the full partial last word.
REQ-031 When PROG_LOADER_CHECKSUM_EN is defined:
- After the last bit, the FSM enters CHECK with data_ready=1 and accepts one trailer word.
- It sets err=1 if the trailer differs from the running XOR, otherwise err=0.
- It then enters DONE with done=1.
- abort is honoured in CHECK.
REQ-032 Without PROG_LOADER_CHECKSUM_EN, the SHALL-NOT conditions are:
- the CHECK state does not exist
- err is tied to 0
- no trailer word is consumed.

Structure
REQ-033 The state encoding typedef and the state constants SHALL live in shared package prog_pkg.
REQ-034 The serializer (word register, bit index, prog_in/prog_en drive) SHALL be the sub-module prog_serializer; the FSM and counters stay in prog_loader.

Verification
REQ-035 CHAIN_LEN=20, words 0xA5, 0x3C, 0xF0:
- prog_en is 1 for exactly 20 cycles.
- The prog_in sequence is 1010_0101_0011_1100_1111.
- done=1 one cycle after the last shift.
- A model chain of five 4-bit prog_mux stages holds the expected selects.
REQ-036 Same load with data_valid deasserted for 5 cycles between words: identical bit sequence, total prog_en count still 20, and prog_en=0 during the gap.
REQ-037 abort asserted on the 10th prog_en cycle: prog_en=0 next cycle, busy=0, done=0; a subsequent start and full load completes normally.
REQ-038 prog_rst asserted mid-SHIFT: all outputs are 0 next cycle and the state is IDLE; start asserted while busy is ignored.
REQ-039 With PROG_LOADER_CHECKSUM_EN defined:
- Trailer 0x69 gives err=0, done=1.
- Trailer 0x68 gives err=1, done=1.
- err clears on the next start.

Source files
------------

// File: rtl/prog_pkg.sv
// prog_pkg: FSM state encoding shared by the prog_loader slice; CHECK exists only with PROG_LOADER_CHECKSUM_EN.
package prog_pkg;
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } prog_state_e;
endpackage

// File: rtl/prog_serializer.sv
// prog_serializer: word register and bit index driving registered prog_in/prog_en, MSB first.
module prog_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data_in,
  output logic              prog_in,
  output logic              prog_en,
  output logic              word_end
);
  localparam int IW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] sr;
  logic [IW-1:0] idx;
  // load emits the MSB immediately, so sr keeps only the bits still to go
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      sr <= '0;
      idx <= '0;
      prog_in <= 1'b0;
      prog_en <= 1'b0;
    end else begin
      sr <= load ? data_in << 1 : shift ? sr << 1 : sr;
      idx <= load ? IW'(1) : shift ? idx + IW'(1) : idx;
      prog_in <= load ? data_in[WORD_W-1] : shift & sr[WORD_W-1];
      prog_en <= load | shift;
    end
  end
  assign word_end = idx == IW'(WORD_W);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams data words into a serial config chain of CHAIN_LEN bits.
// Define PROG_LOADER_CHECKSUM_EN to require an XOR trailer word checked into err.
module prog_loader
  import prog_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  prog_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic load, shift, clr, word_end, last;
  assign last = cnt == CW'(CHAIN_LEN);
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= clr ? '0 : (load | shift) ? cnt + CW'(1) : cnt;
    end
  end
  // the chain-length test precedes the word-end test so a partial last word is cut short
  always_comb begin
    nxt = state;
    load = 1'b0;
    shift = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE, DONE: if (!abort && start) begin
        nxt = FETCH;
        clr = 1'b1;
      end
      FETCH: if (abort) nxt = IDLE;
      else if (data_valid) begin
        nxt = SHIFT;
        load = 1'b1;
      end
      SHIFT: if (abort) nxt = IDLE;
`ifdef PROG_LOADER_CHECKSUM_EN
      else if (last) nxt = CHECK;
`else
      else if (last) nxt = DONE;
`endif
      else if (word_end) nxt = FETCH;
      else shift = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: if (abort) nxt = IDLE;
      else if (data_valid) nxt = DONE;
`endif
      default: nxt = IDLE;
    endcase
  end
  prog_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk(prog_clk),
    .prog_rst(prog_rst),
    .load(load),
    .shift(shift),
    .data_in(data_in),
    .prog_in(prog_in),
    .prog_en(prog_en),
    .word_end(word_end)
  );
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  logic err_q, take;
  assign data_ready = state == FETCH || state == CHECK;
  assign take = state == CHECK && !abort && data_valid;
  always_ff @(posedge prog_clk) begin
    if (prog_rst || clr) begin
      csum <= '0;
      err_q <= 1'b0;
    end else begin
      csum <= load ? csum ^ data_in : csum;
      err_q <= take ? data_in != csum : err_q;
    end
  end
  assign err = err_q;
`else
  assign data_ready = state == FETCH;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed load/gap/abort/reset sequences with a bit scoreboard and model prog_mux chain.
module tb_prog_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  logic prog_clk = 1'b0;
  logic prog_rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic data_valid = 1'b0;
  logic [WW-1:0] data_in = '0;
  logic data_ready, prog_in, prog_en, busy, done, err;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int last_en = 0;
  int done_cyc = 0;
  int pushed = 0;
  bit mon_on = 1'b0;
  bit done_q = 1'b0;
  bit q[$];
  logic [CL-1:0] chain = '0;

  prog_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk),
    .prog_rst(prog_rst),
    .start(start),
    .abort(abort),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .prog_in(prog_in),
    .prog_en(prog_en),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  // scoreboard: every prog_en cycle pops one expected bit and shifts the model chain
  always @(negedge prog_clk) begin
    if (mon_on) begin
      cyc++;
      if (prog_en) begin
        en_cnt++;
        last_en = cyc;
        chain = {chain[CL-2:0], prog_in};
        chk("bit_avail", q.size() > 0, 1);
        if (q.size() > 0) chk("prog_in_bit", prog_in, q.pop_front());
      end else chk("prog_in_idle", prog_in, 0);
      if (done && !done_q) done_cyc = cyc;
      done_q = done;
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!data_ready && n < 50) begin
      tick;
      n++;
    end
    chk(tag, data_ready, 1);
  endtask

  task automatic start_load;
    en_cnt = 0;
    pushed = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    wait_ready("fetch_ready");
    repeat (gap) begin
      tick;
      chk("gap_en", prog_en, 0);
      chk("gap_ready", data_ready, 1);
    end
    for (int i = 0; i < WW && pushed < CL; i++) begin
      q.push_back(w[WW-1-i]);
      pushed++;
    end
    data_in = w;
    data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
    data_in = '0;
    chk("first_bit_en", prog_en, 1);
  endtask

  task automatic run_load(input int gap, input logic [WW-1:0] trailer);
    int n = 0;
    logic [CL-1:0] exp_chain = 20'hA53CF;
    start_load;
    send_word(8'hA5, 0);
    send_word(8'h3C, gap);
    send_word(8'hF0, gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    wait_ready("trailer_ready");
    data_in = trailer;
    data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
    data_in = '0;
`endif
    while (!done && n < 60) begin
      tick;
      n++;
    end
    chk("done", done, 1);
    @(negedge prog_clk);
    #1;
    chk("en_count", en_cnt, CL);
    chk("q_empty", q.size(), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("err", err, trailer != 8'h69);
`else
    chk("done_latency", done_cyc - last_en, 1);
    chk("err_tied", err, 0);
`endif
    chk("done_busy", busy, 0);
    chk("done_ready", data_ready, 0);
    for (int k = 0; k < CL / 4; k++) chk("mux_sel", chain[CL-1-4*k -: 4], exp_chain[CL-1-4*k -: 4]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    chk("rst_ready", data_ready, 0);
    chk("rst_prog_in", prog_in, 0);
    chk("rst_prog_en", prog_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    prog_rst = 1'b0;
    mon_on = 1'b1;
    tick;
    chk("idle_busy", busy, 0);
    run_load(0, 8'h69);
    run_load(5, 8'h69);
    start_load;
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    tick;
    chk("abort_10th_en", prog_en, 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_en", prog_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", data_ready, 0);
    chk("abort_en_count", en_cnt, 10);
    q.delete();
    repeat (3) tick;
    chk("abort_idle", busy, 0);
    run_load(0, 8'h69);
    start_load;
    send_word(8'hA5, 0);
    repeat (2) tick;
    chk("mid_shift_en", prog_en, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    chk("busy_start_en", prog_en, 1);
    chk("busy_start_ready", data_ready, 0);
    prog_rst = 1'b1;
    tick;
    chk("mrst_ready", data_ready, 0);
    chk("mrst_prog_in", prog_in, 0);
    chk("mrst_prog_en", prog_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    prog_rst = 1'b0;
    q.delete();
    repeat (2) tick;
    chk("mrst_idle", busy, 0);
    chk("mrst_idle_en", prog_en, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    run_load(0, 8'h68);
    start_load;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("cs_abort_busy", busy, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
